program_counter_unit: RTL and testbench
=======================================

// Module: program_counter_unit
// PURPOSE
//  Fetch-stage PC generator for the MIPS core. It is the generalised successor of the basic
//  PC register, adding the following:
//   - parametrised address width and vectors
//   - stall
//   - jump-register
//   - six branch conditions
//   - exception redirect with EPC capture
//   - a return-address stack (RAS) for jal/jr $ra
//  It sits between decode/execute control and the instruction memory address port.
// PARAMETERS
//  WIDTH        32            PC/address width; legal range 28..64
//  RESET_VECTOR 32'h0000_0000 PC value loaded on reset
//  EXC_VECTOR   32'h0000_0180 PC value loaded on exception
//  RAS_DEPTH    4             RAS entries; power of two, 2..16
// PORTS
//  clock          in   1        rising-edge clock
//  reset          in   1        synchronous, active-high reset
//  stall          in   1        hold PC; suppress RAS ops
//  exception      in   1        redirect to EXC_VECTOR (overrides stall)
//  jump           in   1        J-type jump
//  jump_addr      in   26       J-type target field
//  jump_reg       in   1        jr/jalr
//  reg_addr       in   WIDTH    register target for jump_reg
//  branch         in   1        conditional branch instruction
//  branch_offset  in   WIDTH    sign-extended word offset
//  cond           in   3        0 eq, 1 ne, 2 lez, 3 gtz, 4 ltz, 5 gez, 6/7 never taken
//  zero, negative in   1 each   ALU flags of the compare
//  link           in   1        push return address (jal/jalr)
//  ret            in   1        pop RAS (jr $ra)
//  pc             out  WIDTH    current PC (registered)
//  pc_next        out  WIDTH    combinational next-PC
//  epc            out  WIDTH    PC of the excepting instruction
//  ras_top        out  WIDTH    top RAS entry; 0 when empty
//  ras_empty      out  1        RAS holds 0 entries
//  ras_full       out  1        RAS holds RAS_DEPTH entries
// BEHAVIOUR
//  - Reset: pc=RESET_VECTOR, epc=0, RAS count=0, ras_empty=1, ras_full=0, ras_top=0.
//  - Derived addresses:
//    - pc_inc = pc+4
//    - jump target = {pc_inc[WIDTH-1:28], jump_addr, 2'b00}
//    - branch target = pc_inc + (branch_offset<<2)
//    - all sums wrap modulo 2^WIDTH
//  - Taken: eq=zero, ne=!zero, lez=zero|negative, gtz=!zero&!negative, ltz=negative,
//    gez=!negative.
//  - pc_next priority: exception > stall(pc) > jump_reg(reg_addr) > jump > branch&taken >
//    pc_inc. pc<=pc_next each cycle (latency 1).
//  - Exception: epc<=pc; pc<=EXC_VECTOR; RAS untouched; link/ret ignored that cycle.
//  - Stall without exception: pc, epc and RAS hold.
//  - RAS push, when link & (jump|jump_reg) & !stall & !exception:
//    - push pc+8, the address past the delay slot
//    - when full, overwrite the oldest entry (circular); count stays RAS_DEPTH
//  - RAS pop, when ret & jump_reg & !stall & !exception:
//    - when empty, no-op; ras_top stays 0
//    - pc still takes reg_addr; the RAS never steers pc
//  - Push and pop in the same cycle (jalr with ret): replace top; count unchanged; when empty,
//    behave as a push.
//  - link or ret without jump/jump_reg: ignored.
//  - Reset mid-operation (including during stall or exception) wins: state returns to reset values.
// TESTING
//  - Reset, then 3 free-running cycles -> pc=0,4,8,C; epc=0; ras_empty=1.
//  - pc=0x100, branch, cond=1, zero=0, offset=-2 -> pc=0xFC; with zero=1 -> pc=0x104.
//  - pc=0x3000_0010, jump, jump_addr=0x40 -> pc=0x3000_0100; stall high 2 cycles -> pc holds 0x3000_0100.
//  - exception with stall=1 at pc=0x200 -> pc=0x180, epc=0x200, RAS count unchanged.
//  - 5 jal pushes with RAS_DEPTH=4 -> ras_full=1; 4 ret pops -> ras_empty=1; 5th pop -> ras_top=0, no error.
//  - jalr+ret at pc=0x40 with one entry -> ras_top=0x48, count still 1; reset asserted mid-stall -> pc=RESET_VECTOR next cycle.

Source files
------------

// File: rtl/program_counter_unit.sv
// Fetch-stage PC generator: sequential/branch/jump/jump-register selection,
// exception redirect with EPC capture, and a circular return-address stack.
module program_counter_unit #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]   EXC_VECTOR   = 'h180,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             exception,
  input  logic             jump,
  input  logic [25:0]      jump_addr,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_addr,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic [2:0]       cond,
  input  logic             zero,
  input  logic             negative,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam int              PTR_W   = $clog2(RAS_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] branch_target;
  logic             taken;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_ptr_inc;
  logic [PTR_W-1:0] ras_ptr_dec;
  logic [CNT_W-1:0] ras_cnt;

  assign pc_inc        = pc + WIDTH'(4);
  assign ret_addr      = pc + WIDTH'(8);
  assign branch_target = pc_inc + (branch_offset << 2);
  assign ras_ptr_inc   = ras_ptr + 1'b1;
  assign ras_ptr_dec   = ras_ptr - 1'b1;

  // With WIDTH=28 the jump field covers the whole address, so no upper bits remain.
  if (WIDTH > 28) begin : g_jt_region
    assign jump_target = {pc_inc[WIDTH-1:28], jump_addr, 2'b00};
  end else begin : g_jt_full
    assign jump_target = {jump_addr, 2'b00};
  end

  // RAS operations only happen on a real jal/jalr/jr that is actually retiring this cycle.
  assign push = link & (jump | jump_reg) & ~stall & ~exception;
  assign pop  = ret & jump_reg & ~stall & ~exception;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == DEPTH_C);
  assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr];

  // Branch condition decode; codes 6 and 7 are never taken.
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'd0:    taken = zero;
      3'd1:    taken = ~zero;
      3'd2:    taken = zero | negative;
      3'd3:    taken = ~zero & ~negative;
      3'd4:    taken = negative;
      3'd5:    taken = ~negative;
      default: taken = 1'b0;
    endcase
  end

  // Next-PC selection in priority order.
  always_comb begin
    pc_next = pc_inc;
    if (exception)             pc_next = EXC_VECTOR;
    else if (stall)            pc_next = pc;
    else if (jump_reg)         pc_next = reg_addr;
    else if (jump)             pc_next = jump_target;
    else if (branch && taken)  pc_next = branch_target;
  end

  // PC and EPC registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc  <= RESET_VECTOR;
      epc <= '0;
    end else begin
      pc <= pc_next;
      if (exception) epc <= pc;
    end
  end

  // Return-address stack; a push when full advances onto the oldest slot, overwriting it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (push && (!pop || ras_empty)) begin
      ras_ptr              <= ras_ptr_inc;
      ras_mem[ras_ptr_inc] <= ret_addr;
      if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
    end else if (push && pop) begin
      ras_mem[ras_ptr] <= ret_addr;
    end else if (pop && !ras_empty) begin
      ras_ptr <= ras_ptr_dec;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed-vector bench for program_counter_unit with hand-computed expectations.
module tb_program_counter_unit;

  logic        clock = 1'b0;
  logic        reset, stall, exception, jump, jump_reg, branch;
  logic [25:0] jump_addr;
  logic [31:0] reg_addr, branch_offset;
  logic [2:0]  cond;
  logic        zero, negative, link, ret;
  logic [31:0] pc, pc_next, epc, ras_top;
  logic        ras_empty, ras_full;

  int vec_cnt = 0;
  int err_cnt = 0;

  program_counter_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0000_0000), .EXC_VECTOR(32'h0000_0180), .RAS_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .exception(exception),
    .jump(jump), .jump_addr(jump_addr), .jump_reg(jump_reg), .reg_addr(reg_addr),
    .branch(branch), .branch_offset(branch_offset), .cond(cond),
    .zero(zero), .negative(negative), .link(link), .ret(ret),
    .pc(pc), .pc_next(pc_next), .epc(epc), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    reset = 0; stall = 0; exception = 0; jump = 0; jump_reg = 0; branch = 0;
    jump_addr = '0; reg_addr = '0; branch_offset = '0; cond = 3'd7;
    zero = 0; negative = 0; link = 0; ret = 0;
  endtask

  task automatic set_pc(input logic [31:0] a);
    clr(); jump_reg = 1; reg_addr = a; step(); clr();
  endtask

  task automatic do_branch(input logic [2:0] c, input logic z, input logic n,
                           input logic [31:0] off, input logic [31:0] exp, input string tag);
    clr(); branch = 1; cond = c; zero = z; negative = n; branch_offset = off;
    step(); check_val(tag, pc, exp); clr();
  endtask

  initial begin
    clr();
    reset = 1; step(); step();
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_epc", epc, 32'h0);
    check_val("rst_empty", ras_empty, 1);
    check_val("rst_full", ras_full, 0);
    check_val("rst_top", ras_top, 32'h0);
    clr();
    step(); check_val("seq1", pc, 32'h4);
    step(); check_val("seq2", pc, 32'h8);
    step(); check_val("seq3", pc, 32'hC);
    check_val("pc_next_inc", pc_next, 32'h10);

    // Branches
    set_pc(32'h100); check_val("jr_0x100", pc, 32'h100);
    do_branch(3'd1, 0, 0, 32'hFFFF_FFFE, 32'h0FC, "bne_taken");
    set_pc(32'h100);
    do_branch(3'd1, 1, 0, 32'hFFFF_FFFE, 32'h104, "bne_not");
    do_branch(3'd2, 0, 1, 32'h4,         32'h118, "blez_neg");
    do_branch(3'd3, 0, 0, 32'h1,         32'h120, "bgtz_taken");
    do_branch(3'd4, 0, 0, 32'h1,         32'h124, "bltz_not");
    do_branch(3'd5, 0, 0, 32'h2,         32'h130, "bgez_taken");
    do_branch(3'd0, 1, 0, 32'hFFFF_FFFF, 32'h130, "beq_back");
    do_branch(3'd7, 1, 1, 32'h10,        32'h134, "never");

    // Jump keeps the PC region bits, then stall holds
    set_pc(32'h3000_0010);
    jump = 1; jump_addr = 26'h40; step(); clr();
    check_val("j_region", pc, 32'h3000_0100);
    stall = 1; jump = 1; jump_addr = 26'h1; step();
    check_val("stall1", pc, 32'h3000_0100);
    step(); check_val("stall2", pc, 32'h3000_0100);
    clr();

    // Exception beats stall; link on that cycle is ignored
    set_pc(32'h200);
    exception = 1; stall = 1; link = 1; jump = 1; jump_addr = 26'h10; step(); clr();
    check_val("exc_pc", pc, 32'h180);
    check_val("exc_epc", epc, 32'h200);
    check_val("exc_ras", ras_empty, 1);

    // Five jal pushes into a 4-deep RAS
    set_pc(32'h1000);
    for (int k = 0; k < 5; k++) begin
      link = 1; jump = 1; jump_addr = 26'h400 + 26'((k + 1) * 'h40);
      step();
      check_val($sformatf("push%0d_top", k), ras_top, 32'h1008 + 32'(k * 'h100));
      check_val($sformatf("push%0d_pc", k), pc, 32'h1000 + 32'((k + 1) * 'h100));
    end
    clr();
    check_val("ras_full", ras_full, 1);
    check_val("ras_not_empty", ras_empty, 0);
    // Four pops; 0x1008 was overwritten, so the last remaining entry is 0x1108
    ret = 1; jump_reg = 1; reg_addr = 32'h2000;
    step(); check_val("pop1_top", ras_top, 32'h1308);
    check_val("pop1_full", ras_full, 0);
    step(); check_val("pop2_top", ras_top, 32'h1208);
    step(); check_val("pop3_top", ras_top, 32'h1108);
    step(); check_val("pop4_empty", ras_empty, 1);
    check_val("pop4_top", ras_top, 32'h0);
    step(); check_val("pop5_top", ras_top, 32'h0);
    check_val("pop5_empty", ras_empty, 1);
    check_val("pop5_pc", pc, 32'h2000);
    clr();

    // jalr push, stray ret ignored, then jalr+ret replaces top at pc=0x40
    link = 1; jump_reg = 1; reg_addr = 32'h3C; step(); clr();
    check_val("jalr_top", ras_top, 32'h2008);
    ret = 1; step(); clr();
    check_val("ret_alone_top", ras_top, 32'h2008);
    check_val("ret_alone_pc", pc, 32'h40);
    link = 1; ret = 1; jump_reg = 1; reg_addr = 32'h500; step(); clr();
    check_val("repl_top", ras_top, 32'h48);
    check_val("repl_pc", pc, 32'h500);
    ret = 1; jump_reg = 1; reg_addr = 32'h600; step(); clr();
    check_val("repl_cnt1", ras_empty, 1);

    // Push onto an empty stack with jalr+ret behaves as a plain push
    link = 1; ret = 1; jump_reg = 1; reg_addr = 32'h700; step(); clr();
    check_val("repl_empty_top", ras_top, 32'h608);
    check_val("repl_empty_ne", ras_empty, 0);

    // Reset during stall wins
    exception = 1; step(); clr();
    stall = 1; step();
    check_val("pre_rst_epc", epc, 32'h700);
    reset = 1; step(); clr();
    check_val("rst_mid_pc", pc, 32'h0);
    check_val("rst_mid_epc", epc, 32'h0);
    check_val("rst_mid_empty", ras_empty, 1);
    check_val("rst_mid_top", ras_top, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
